// File: rtl/arm_pkg.sv
// Shared definitions for the ARM datapath control slice: condition-code encodings
// (Instr[31:28]), NZCV flag bit positions and FlagW request bit positions.
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Flag register / ALUFlags bit positions, order {N, Z, C, V}.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // FlagW request bits: [1] writes N,Z; [0] writes C,V.
  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Control bundle between the main decoder and the conditional-execution unit.
//   master : decoder side, drives the condition field, ALU flags and raw strobes,
//            receives the gated write enables and flag state.
//   slave  : cond_unit side.
interface cond_unit_if;
  logic [3:0] Cond;        // Instr[31:28]
  logic [3:0] ALUFlags;    // {N, Z, C, V} from the ALU
  logic [1:0] FlagW;       // [1] N,Z  [0] C,V
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;     // compare-class op, never writes Rd
  logic       InstrValid;
  logic       Stall;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic       CondExReg;
  logic [3:0] Flags;       // stored {N, Z, C, V}

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, InstrValid, Stall,
    input  PCSrc, RegWrite, MemWrite, CondEx, CondExReg, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, InstrValid, Stall,
    output PCSrc, RegWrite, MemWrite, CondEx, CondExReg, Flags
  );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator.
//   cond_i      : 4-bit condition field
//   flags_i     : stored flags {N, Z, C, V}
//   cond_pass_o : 1 when the condition holds for the given flags
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    cond_pass_o = 1'b0;
    unique case (cond_i)
      COND_EQ: cond_pass_o = z;
      COND_NE: cond_pass_o = ~z;
      COND_CS: cond_pass_o = c;
      COND_CC: cond_pass_o = ~c;
      COND_MI: cond_pass_o = n;
      COND_PL: cond_pass_o = ~n;
      COND_VS: cond_pass_o = v;
      COND_VC: cond_pass_o = ~v;
      COND_HI: cond_pass_o = c & ~z;
      COND_LS: cond_pass_o = ~c | z;
      COND_GE: cond_pass_o = (n == v);
      COND_LT: cond_pass_o = (n != v);
      COND_GT: cond_pass_o = ~z & (n == v);
      COND_LE: cond_pass_o = z | (n != v);
      COND_AL: cond_pass_o = 1'b1;
      COND_NV: cond_pass_o = 1'b0;  // reserved encoding, never executes
      default: cond_pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit. Holds the NZCV flag register, evaluates the
// instruction condition against the stored flags and gates the decoder's
// PCS/RegW/MemW strobes into the datapath write enables.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears Flags and CondExReg
//   bus   : cond_unit_if slave (condition, ALU flags, strobes in; gated enables,
//           CondEx, CondExReg and Flags out)
module cond_unit
  import arm_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  cond_unit_if.slave     bus
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_reg_q, cond_ex_reg_d;
  logic       cond_pass;
  logic       cond_ex;
  logic       accept;

  // Evaluated on the stored flags only; the instruction's own ALUFlags land at
  // the end of its cycle, so no forwarding path exists.
  cond_check u_cond_check (
    .cond_i      (bus.Cond),
    .flags_i     (flags_q),
    .cond_pass_o (cond_pass)
  );

  assign cond_ex = bus.InstrValid & cond_pass;
  assign accept  = bus.InstrValid & ~bus.Stall;

  always_comb begin
    flags_d       = flags_q;
    cond_ex_reg_d = cond_ex_reg_q;
    if (accept) begin
      cond_ex_reg_d = cond_ex;
      if (cond_ex) begin
        if (bus.FlagW[FLAGW_NZ]) begin
          flags_d[FLAG_N:FLAG_Z] = bus.ALUFlags[FLAG_N:FLAG_Z];
        end
        if (bus.FlagW[FLAGW_CV]) begin
          flags_d[FLAG_C:FLAG_V] = bus.ALUFlags[FLAG_C:FLAG_V];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q       <= 4'b0000;
      cond_ex_reg_q <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      cond_ex_reg_q <= cond_ex_reg_d;
    end
  end

  assign bus.CondEx    = cond_ex;
  assign bus.PCSrc     = bus.PCS & cond_ex;
  assign bus.RegWrite  = bus.RegW & cond_ex & ~bus.NoWrite;
  assign bus.MemWrite  = bus.MemW & cond_ex;
  assign bus.CondExReg = cond_ex_reg_q;
  assign bus.Flags     = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: expected outputs are pushed to a scoreboard
// queue as each stimulus is applied and popped when the DUT outputs are sampled.
module tb_cond_unit;

  logic clk;
  logic reset;

  cond_unit_if bus ();

  cond_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       condex;
    logic       reg_ok;     // registered state is known (reset seen)
    logic       condexreg;
    logic [3:0] flags;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0] m_flags;
  logic       m_cer;
  logic       m_ok = 1'b0;
  logic       m_condex;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Reference condition evaluation: base test from Cond[3:1], inverted by Cond[0].
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  task automatic pop_compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 8'd0, 8'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("condex",   8'(bus.CondEx),   8'(e.condex));
    check_eq("pcsrc",    8'(bus.PCSrc),    8'(e.pcsrc));
    check_eq("regwrite", 8'(bus.RegWrite), 8'(e.regwrite));
    check_eq("memwrite", 8'(bus.MemWrite), 8'(e.memwrite));
    if (e.reg_ok) begin
      check_eq("condexreg", 8'(bus.CondExReg), 8'(e.condexreg));
      check_eq("flags",     8'(bus.Flags),     8'(e.flags));
    end
  endtask

  // Apply one instruction (called just after a falling edge), then score it.
  task automatic drive(input logic rst, input logic [3:0] cond, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs, input logic regw,
                       input logic memw, input logic nowrite, input logic valid,
                       input logic stall);
    exp_t e;
    reset          = rst;
    bus.Cond       = cond;
    bus.ALUFlags   = alu;
    bus.FlagW      = fw;
    bus.PCS        = pcs;
    bus.RegW       = regw;
    bus.MemW       = memw;
    bus.NoWrite    = nowrite;
    bus.InstrValid = valid;
    bus.Stall      = stall;
    m_condex    = valid & (m_ok ? ref_pass(cond, m_flags) : 1'b0);
    e.condex    = m_condex;
    e.pcsrc     = pcs & m_condex;
    e.regwrite  = regw & m_condex & ~nowrite;
    e.memwrite  = memw & m_condex;
    e.reg_ok    = m_ok;
    e.condexreg = m_cer;
    e.flags     = m_flags;
    exp_q.push_back(e);
    #1;
    pop_compare();
  endtask

  // Advance one clock and update the model with the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_flags = 4'b0000;
      m_cer   = 1'b0;
      m_ok    = 1'b1;
    end else if (bus.InstrValid && !bus.Stall) begin
      m_cer = m_condex;
      if (m_condex) begin
        if (bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
        if (bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
      end
    end
    @(negedge clk);
    #1;
  endtask

  // Load the flag register through an always-executing full flag write.
  task automatic set_flags(input logic [3:0] f);
    drive(1'b0, 4'hE, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // Reset (no instruction), two cycles.
    drive(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // First instruction after reset: AL passes, EQ fails, NE passes on 0000.
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_eq_fail", 8'(bus.CondEx), 8'd0);
    drive(1'b0, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("rst_ne_pass", 8'(bus.PCSrc), 8'd1);
    drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("al_regwrite", 8'(bus.RegWrite), 8'd1);
    tick();
    check_eq("al_flags", 8'(bus.Flags), 8'h0);
    check_eq("al_cer", 8'(bus.CondExReg), 8'd1);

    // SUBS setting Z,C, then dependent EQ / NE branch next cycle.
    drive(1'b0, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("subs_flags", 8'(bus.Flags), 8'h6);
    check_eq("beq_taken", 8'(bus.PCSrc), 8'd1);
    drive(1'b0, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("bne_not", 8'(bus.PCSrc), 8'd0);
    tick();

    // Signed compares on N=1, V=0 (stalled so nothing moves).
    set_flags(4'b1000);
    drive(1'b0, 4'hB, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("lt", 8'(bus.CondEx), 8'd1);
    drive(1'b0, 4'hA, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("ge", 8'(bus.CondEx), 8'd0);
    drive(1'b0, 4'hC, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("gt", 8'(bus.CondEx), 8'd0);
    drive(1'b0, 4'hD, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("le", 8'(bus.CondEx), 8'd1);
    tick();

    // Partial flag writes.
    set_flags(4'b1111);
    drive(1'b0, 4'hE, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("fw_nz", 8'(bus.Flags), 8'h3);
    set_flags(4'b1111);
    drive(1'b0, 4'hE, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("fw_cv", 8'(bus.Flags), 8'hC);

    // Failed condition blocks writes and flag update.
    set_flags(4'b0000);
    drive(1'b0, 4'h0, 4'hF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("fail_memw", 8'(bus.MemWrite), 8'd0);
    tick();
    check_eq("fail_flags", 8'(bus.Flags), 8'h0);
    check_eq("fail_cer", 8'(bus.CondExReg), 8'd0);

    // Stall holds flags and CondExReg.
    drive(1'b0, 4'hE, 4'hF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("stall_comb", 8'(bus.RegWrite), 8'd1);
    tick();
    check_eq("stall_flags", 8'(bus.Flags), 8'h0);
    check_eq("stall_cer", 8'(bus.CondExReg), 8'd0);

    // Reset dominates a concurrent flag write.
    set_flags(4'b0101);
    drive(1'b1, 4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("rstpri_flags", 8'(bus.Flags), 8'h0);
    check_eq("rstpri_cer", 8'(bus.CondExReg), 8'd0);

    // Sweep all conditions against all flag values with random strobes.
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        logic pcs, regw, memw, nw;
        pcs  = 1'($urandom);
        regw = 1'($urandom);
        memw = 1'($urandom);
        nw   = 1'($urandom);
        drive(1'b0, 4'(c), 4'($urandom), 2'($urandom), pcs, regw, memw, nw, 1'b1, 1'b1);
        if (c == 15) check_eq("nv_never", 8'(bus.CondEx), 8'd0);
        if (nw) check_eq("nowrite", 8'(bus.RegWrite), 8'd0);
      end
      // One accepted random instruction per flag value exercises the update path.
      drive(1'b0, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0, 1'b1, 1'b0, 1'b0,
            1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
